// File: rtl/mulmod_pkg.sv
// Shared types and constants for the Barrett modular multiplier.
package mulmod_pkg;

  typedef enum logic [1:0] {
    ST_UNCONF = 2'd0,
    ST_CALC   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int PIPE_LAT = 4;

  function automatic int mu_width(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/mulmod_pipe_if.sv
// Config, operand and result handshakes of the modular multiplier.
interface mulmod_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              cfg_valid;
  logic [DATA_W-1:0] cfg_modulus;
  logic              cfg_ready;
  logic              cfg_err;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  modport master (
    output cfg_valid, cfg_modulus, in_valid, a_in, b_in, in_tag, out_ready,
    input  cfg_ready, cfg_err, in_ready, out_valid, result, out_tag, busy
  );

  modport slave (
    input  cfg_valid, cfg_modulus, in_valid, a_in, b_in, in_tag, out_ready,
    output cfg_ready, cfg_err, in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/barrett_mu_div.sv
// Restoring divider producing mu = floor(2^(2*DATA_W) / m), one quotient bit per cycle.
module barrett_mu_div
  import mulmod_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_W-1:0]             m,
  output logic                          done,
  output logic [mu_width(DATA_W)-1:0]   mu
);

  localparam int MU_W  = mu_width(DATA_W);
  localparam int ITER  = 2 * DATA_W + 1;
  localparam int CNT_W = $clog2(ITER + 1);

  logic              running;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W:0]   rem_sh;
  logic              q_bit;
  logic [DATA_W-1:0] rem_nxt;

  // Dividend is a single 1 followed by 2*DATA_W zeros: only the first step shifts in a 1.
  always_comb begin
    rem_sh  = {rem, (cnt == CNT_W'(ITER))};
    q_bit   = (rem_sh >= {1'b0, m});
    rem_nxt = q_bit ? DATA_W'(rem_sh - {1'b0, m}) : rem_sh[DATA_W-1:0];
  end

  assign done = running && (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      mu      <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CNT_W'(ITER);
      mu      <= '0;
    end else if (running) begin
      running <= (cnt != CNT_W'(1));
      cnt     <= cnt - CNT_W'(1);
      mu      <= {mu[MU_W-2:0], q_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem <= '0;
    end else if (running) begin
      rem <= rem_nxt;
    end
  end

endmodule

// File: rtl/mulmod_pipe.sv
// Fully pipelined (a*b) mod m using Barrett reduction; mu is derived on modulus load.
module mulmod_pipe
  import mulmod_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input logic          clk,
  input logic          rst,
  mulmod_pipe_if.slave bus
);

  localparam int MU_W = mu_width(DATA_W);

  state_e state_q, state_d;
  logic [DATA_W-1:0] m_q;
  logic [MU_W-1:0]   mu;
  logic              div_start, div_done;
  logic              cfg_fire, cfg_legal, cfg_err_q;
  logic              adv, in_fire, pipe_empty;
  logic [PIPE_LAT:0] vld_all;

  logic              vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;
  logic [TAG_W-1:0]  tag_p0, tag_p1, tag_p2, tag_p3, tag_p4;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic [2*DATA_W-1:0] x_p1, x_p2;
  logic [DATA_W+1:0] q_p2, r_p3;
  logic [DATA_W-1:0] result_p4;

  logic [2*DATA_W+2:0] q_prod;
  logic [DATA_W+1:0]   q_calc;
  logic [2*DATA_W+1:0] qm_full;
  logic [DATA_W+1:0]   r_calc;

  function automatic logic [DATA_W-1:0] final_reduce(input logic [DATA_W+1:0] r,
                                                     input logic [DATA_W-1:0] m);
    logic [DATA_W+1:0] m1, m2;
    m1 = {2'b00, m};
    m2 = {1'b0, m, 1'b0};
    if (r >= m2)      return DATA_W'(r - m2);
    else if (r >= m1) return DATA_W'(r - m1);
    else              return DATA_W'(r);
  endfunction

  barrett_mu_div #(.DATA_W(DATA_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .m     (m_q),
    .done  (div_done),
    .mu    (mu)
  );

  assign vld_all    = {vld_p4, vld_p3, vld_p2, vld_p1, vld_p0};
  assign pipe_empty = ~(|vld_all);
  assign adv        = !vld_p4 || bus.out_ready;
  assign cfg_legal  = bus.cfg_modulus[DATA_W-1] && (|bus.cfg_modulus[DATA_W-2:0]);
  assign cfg_fire   = bus.cfg_valid && bus.cfg_ready;
  assign in_fire    = bus.in_valid && bus.in_ready;

  assign bus.cfg_ready = (state_q != ST_CALC) && pipe_empty;
  assign bus.in_ready  = (state_q == ST_RUN) && !bus.cfg_valid && adv;
  assign bus.busy      = (state_q == ST_CALC) || !pipe_empty;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.out_valid = vld_p4;
  assign bus.result    = result_p4;
  assign bus.out_tag   = tag_p4;

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      ST_CALC: if (div_done) state_d = ST_RUN;
      default: begin
        if (cfg_fire && cfg_legal) begin
          state_d   = ST_CALC;
          div_start = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_UNCONF;
      m_q       <= '0;
      cfg_err_q <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      vld_p4    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_fire && !cfg_legal;
      if (div_start) m_q <= bus.cfg_modulus;
      if (adv) begin
        vld_p0 <= in_fire;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
        vld_p3 <= vld_p2;
        vld_p4 <= vld_p3;
      end
    end
  end

  // S2: Barrett quotient estimate, at most 2 below the true quotient
  assign q_prod = {{(DATA_W+2){1'b0}}, x_p1[2*DATA_W-1:DATA_W-1]} * {{(DATA_W+1){1'b0}}, mu};
  assign q_calc = (DATA_W+2)'(q_prod >> (DATA_W+1));

  // S3: remainder modulo 2^(DATA_W+2), guaranteed below 3m
  assign qm_full = {{DATA_W{1'b0}}, q_p2} * {{(DATA_W+2){1'b0}}, m_q};
  assign r_calc  = (DATA_W+2)'({2'b00, x_p2} - qm_full);

  // Input capture and S1..S3 data registers
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p0   <= bus.a_in;
      b_p0   <= bus.b_in;
      tag_p0 <= bus.in_tag;
      x_p1   <= {{DATA_W{1'b0}}, a_p0} * {{DATA_W{1'b0}}, b_p0};
      tag_p1 <= tag_p0;
      x_p2   <= x_p1;
      q_p2   <= q_calc;
      tag_p2 <= tag_p1;
      r_p3   <= r_calc;
      tag_p3 <= tag_p2;
    end
  end

  // S4: final conditional subtraction into the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p4 <= '0;
      tag_p4    <= '0;
    end else if (adv) begin
      result_p4 <= final_reduce(r_p3, m_q);
      tag_p4    <= tag_p3;
    end
  end

endmodule

// File: tb/tb_mulmod_pipe.sv
// Directed bench for mulmod_pipe with a queue-based (a*b)%m reference model.
module tb_mulmod_pipe;
  localparam int W  = 14;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mulmod_pipe_if #(.DATA_W(W), .TAG_W(TW)) bus ();
  mulmod_pipe #(.DATA_W(W), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { longint res; longint tag; } exp_t;
  exp_t   sb_q[$];
  longint model_m = 0;
  int     n_chk = 0;
  int     n_pass = 0;
  int     n_pop = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit legal(input longint m);
    return (m > (64'd1 << (W-1))) && (m < (64'd1 << W));
  endfunction

  // Reference model and per-cycle output compare
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.cfg_valid && bus.cfg_ready && legal(longint'(bus.cfg_modulus)))
        model_m = longint'(bus.cfg_modulus);
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("sb_result", longint'(bus.result), sb_q[0].res);
          check("sb_tag", longint'(bus.out_tag), sb_q[0].tag);
          if (bus.out_ready) begin
            void'(sb_q.pop_front());
            n_pop++;
          end
        end
        if (!bus.out_ready) check("stall_in_ready", longint'(bus.in_ready), 0);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.res = (longint'(bus.a_in) * longint'(bus.b_in)) % model_m;
        e.tag = longint'(bus.in_tag);
        sb_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input longint m);
    bit ok = 0;
    bus.cfg_valid   = 1'b1;
    bus.cfg_modulus = W'(m);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cfg_ready) begin ok = 1; break; end
    end
    if (!ok) check("cfg_handshake_timeout", 0, 1);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_in_ready(output int k);
    k = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.in_ready) begin k = i; break; end
    end
  endtask

  task automatic send(input longint a, input longint b, input longint tag);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.a_in     = W'(a);
    bus.b_in     = W'(b);
    bus.in_tag   = TW'(tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
      @(posedge clk);
    end
    if (!ok) check("send_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_out(output int k);
    k = -1;
    for (int i = 0; i <= 40; i++) begin
      if (bus.out_valid) begin k = i; break; end
      tick();
    end
  endtask

  task automatic single(input longint a, input longint b, input longint tag,
                        input longint exp_res, input string name);
    int k;
    send(a, b, tag);
    bus.in_valid = 1'b0;
    wait_out(k);
    check({name, "_latency"}, k, 4);
    check({name, "_result"}, longint'(bus.result), exp_res);
    check({name, "_tag"}, longint'(bus.out_tag), tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int pops0;
    int seen;
    longint stream_exp [4] = '{1, 0, 12288, 12288};
    longint stream_a   [4] = '{12288, 0, 1, 6144};
    longint stream_b   [4] = '{12288, 777, 12288, 2};

    bus.cfg_valid = 0; bus.cfg_modulus = '0; bus.in_valid = 0;
    bus.a_in = '0; bus.b_in = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cfg_ready", bus.cfg_ready, 1);
    rst = 1'b0;
    tick();

    // Modulus load and mu computation
    do_cfg(12289);
    check("calc_busy", bus.busy, 1);
    check("calc_cfg_ready", bus.cfg_ready, 0);
    wait_in_ready(k);
    check("cfg_latency", k, 29);

    single(5000, 7000, 3, 928, "op5000x7000");

    // Back-to-back stream
    for (int i = 0; i < 4; i++) send(stream_a[i], stream_b[i], i + 1);
    bus.in_valid = 1'b0;
    wait_out(k);
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", bus.out_valid, 1);
      check("stream_result", longint'(bus.result), stream_exp[i]);
      check("stream_tag", longint'(bus.out_tag), i + 1);
      tick();
    end

    // Backpressure mid-stream
    pops0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) send((i * 1531 + 17) % 12289, (i * 977 + 5) % 12289, i);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (6) tick();
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick();
    check("bp_drained", sb_q.size(), 0);
    check("bp_count", n_pop - pops0, 8);

    // Illegal moduli: exactly 2^(W-1) and below
    do_cfg(4096);
    check("ill_cfg_err", bus.cfg_err, 1);
    check("ill_cfg_ready", bus.cfg_ready, 1);
    tick();
    check("ill_cfg_err_pulse", bus.cfg_err, 0);
    check("ill_in_ready", bus.in_ready, 1);
    do_cfg(8192);
    check("bound_cfg_err", bus.cfg_err, 1);
    tick();
    single(100, 200, 5, 7711, "after_illegal");

    // Reset during divider run
    do_cfg(12289);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rstcalc_out_valid", bus.out_valid, 0);
    check("rstcalc_busy", bus.busy, 0);
    check("rstcalc_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.in_ready) seen++; end
    check("rstcalc_unconf", seen, 0);

    // Reset with three pairs in flight
    do_cfg(12289);
    wait_in_ready(k);
    check("reload_latency", k, 29);
    send(11, 12, 1); send(13, 14, 2); send(15, 16, 3);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rstrun_out_valid", bus.out_valid, 0);
    check("rstrun_busy", bus.busy, 0);
    check("rstrun_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (bus.out_valid || bus.in_ready) seen++; end
    check("rstrun_flushed", seen, 0);

    // Largest legal modulus
    do_cfg(16383);
    wait_in_ready(k);
    check("max_m_latency", k, 29);
    single(16382, 16382, 9, 1, "max_m");
    send(12345, 2, 4);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("final_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
